reduce_clause_seq: RTL and testbench
====================================

Name: reduce_clause_seq

Overview:
- Sequential, parametrised successor to the combinational clause reducer.
- Takes one linear integer clause a0*y0 + ... + a(N-1)*y(N-1) + aN, plus the current assignment and a kept-variable index k.
- Substitutes every variable except yk and divides the sum by |ak|, producing the reduced form (+/-)yk <= b.
- Uses one shared multiplier and an iterative restoring divider behind a valid/ready handshake. Sits between the clause store and the per-variable bound sampler.

Parameters:
- NUM_VARS, 2, number of integer variables N.
- WIDTH, 8, bit width of each coefficient, assignment and out_bias (two's complement).
- INDEX_WIDTH, 1, width of the variable index; must be at least clog2(NUM_VARS).
- ACC_W, 2*WIDTH+clog2(NUM_VARS+1), signed accumulator/dividend width (derived; do not override).

Ports:
- in_clk  input  1  clock, all state on rising edge.
- in_reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- out_ready  output  1  block can accept; high only in IDLE.
- in_coefficients  input  (NUM_VARS+1)*WIDTH  signed a0..aN, a0 in LSBs, aN is the constant term.
- in_current_assignment  input  NUM_VARS*WIDTH  signed y0..y(N-1), y0 in LSBs.
- in_variable_to_be_unchanged_index  input  INDEX_WIDTH  kept-variable index k.
- out_valid  output  1  result valid; held until acknowledged.
- in_ack  input  1  downstream accepts the result.
- out_bias  output  WIDTH  signed b.
- out_variable_to_be_unchanged_sign  output  1  1 if ak > 0, 0 if ak < 0.
- out_active  output  1  1 if ak != 0.

Behaviour:
- Clock port is in_clk; reset port is in_reset, synchronous and active-high.
- Reset: state=IDLE; out_ready=1; out_valid, out_bias, sign and out_active = 0. Reset in any state, including mid-ACCUM or mid-DIVIDE, discards the in-flight request with no output.
- Accept: on an edge with in_valid && out_ready, register all inputs. Inputs are don't-care afterwards.
- IDLE -> DONE (inactive path): taken if k >= NUM_VARS or ak == 0. Outputs active=0, bias=0, sign=0. out_valid rises 1 cycle after the accept edge.
- IDLE -> ACCUM: otherwise. Accumulator preloads sign-extended aN.
- ACCUM: exactly NUM_VARS cycles, term i per cycle in order i = 0..N-1. Adds ai*yi (full-precision signed product), or 0 when i == k. Fixed latency regardless of k.
- DIVIDE: exactly ACC_W cycles of restoring division. |acc| is divided by |ak|, one quotient bit per cycle.
  - Quotient magnitude is truncated; sign taken from acc, so rounding is toward zero (matches Verilog signed /).
  - sign = (ak > 0).
- DONE: out_valid=1, out_ready=0. Outputs stable while out_valid && !in_ack.
  - in_ack high -> IDLE next edge; out_valid drops and out_ready rises.
  - No accept occurs in the same cycle as the ack.
  - in_ack outside DONE is ignored. in_valid outside IDLE is ignored.
- Active-path latency: accept edge to out_valid = NUM_VARS + ACC_W cycles (20 at defaults).
- Width rule: out_bias = low WIDTH bits of the signed quotient (two's-complement wrap). ACC_W cannot overflow for any input.
- Division by zero is impossible: ak == 0 always takes the inactive path.

Optional Feature:
- Macro: REDUCE_CLAUSE_SATURATE_EN.
- Defined: adds output port out_overflow (1 bit, reset 0, valid with out_valid).
  - A quotient outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] is clamped to the nearest limit and out_overflow=1.
  - Otherwise out_overflow=0. No added latency.
- Undefined: no out_overflow port; out_bias wraps as above.

Test Plan (defaults N=2, W=8):
- a=(3,2,5), y=(4,7), k=0 -> after 20 cycles: out_valid=1, bias=6 (19/3), sign=1, active=1.
- a=(-4,3,-2), y=(9,-5), k=0 -> acc=-17: bias=-4 (toward zero), sign=0, active=1, latency 20.
- a=(5,0,1), y=(1,1), k=1 -> out_valid 1 cycle after accept: active=0, bias=0, sign=0. Same result for k=2 with INDEX_WIDTH=2.
- Backpressure: hold in_ack low 5 cycles after out_valid, pulse in_valid throughout -> outputs unchanged, out_ready=0, no second accept. Ack -> out_ready=1 next cycle.
- Reset mid-DIVIDE: in_reset high 10 cycles after accept -> next cycle state IDLE, out_ready=1, all outputs 0. A new request then completes normally.
- a=(1,127,127), y=(0,127), k=0 -> acc=16256. Without macro: bias=-128 (wrap). With REDUCE_CLAUSE_SATURATE_EN: bias=127, out_overflow=1.

Source files
------------

// File: rtl/reduce_clause_seq.sv
// Sequential clause reducer: one multiplier, restoring divider, valid/ready in, valid/ack out.
// Optional clamp of out_bias with out_overflow flag under REDUCE_CLAUSE_SATURATE_EN.
module reduce_clause_seq #(
   parameter int NUM_VARS    = 2,
   parameter int WIDTH       = 8,
   parameter int INDEX_WIDTH = 1
) (
   input  logic                          in_clk,
   input  logic                          in_reset,
   input  logic                          in_valid,
   output logic                          out_ready,
   input  logic [(NUM_VARS+1)*WIDTH-1:0] in_coefficients,
   input  logic [NUM_VARS*WIDTH-1:0]     in_current_assignment,
   input  logic [INDEX_WIDTH-1:0]        in_variable_to_be_unchanged_index,
   output logic                          out_valid,
   input  logic                          in_ack,
   output logic [WIDTH-1:0]              out_bias,
   output logic                          out_variable_to_be_unchanged_sign,
   output logic                          out_active
`ifdef REDUCE_CLAUSE_SATURATE_EN
   ,
   output logic                          out_overflow
`endif
);

   localparam int ACC_W = 2*WIDTH + $clog2(NUM_VARS+1);
   localparam int CNT_W = $clog2(ACC_W);

   typedef enum logic [2:0] {
      S_IDLE, S_SKIP, S_ACCUM, S_DIVIDE, S_DONE
   } state_t;

   state_t                      r_state;
   logic [CNT_W-1:0]            r_cnt;
   logic [NUM_VARS*WIDTH-1:0]   r_coef;
   logic [NUM_VARS*WIDTH-1:0]   r_asg;
   logic [INDEX_WIDTH-1:0]      r_k;
   logic [WIDTH-1:0]            r_div;
   logic                        r_sgn;
   logic                        r_neg;
   logic [ACC_W-1:0]            r_acc;
   logic [WIDTH:0]              r_rem;

   logic signed [WIDTH-1:0]     w_ak;
   logic [WIDTH-1:0]            w_ak_mag;
   logic signed [WIDTH-1:0]     w_an;
   logic signed [WIDTH-1:0]     w_ai;
   logic signed [WIDTH-1:0]     w_yi;
   logic signed [2*WIDTH-1:0]   w_prod;
   logic signed [ACC_W-1:0]     w_term;
   logic signed [ACC_W-1:0]     w_acc_nx;
   logic [ACC_W-1:0]            w_acc_abs;
   logic [WIDTH+1:0]            w_rem_sh;
   logic                        w_ge;
   logic [WIDTH:0]              w_diff;
   logic [ACC_W-1:0]            w_q_nx;
   logic [WIDTH-1:0]            w_q_lo;

   // Kept coefficient; an out-of-range index reads as zero so it takes the inactive path.
   always_comb begin
      w_ak = '0;
      for (int i = 0; i < NUM_VARS; i++) begin
         if (int'(in_variable_to_be_unchanged_index) == i)
            w_ak = in_coefficients[i*WIDTH +: WIDTH];
      end
      w_ak_mag = w_ak[WIDTH-1] ? -w_ak : w_ak;
      w_an     = in_coefficients[(NUM_VARS+1)*WIDTH-1 -: WIDTH];
   end

   always_comb begin
      w_ai = '0;
      w_yi = '0;
      for (int i = 0; i < NUM_VARS; i++) begin
         if (int'(r_cnt) == i) begin
            w_ai = r_coef[i*WIDTH +: WIDTH];
            w_yi = r_asg[i*WIDTH +: WIDTH];
         end
      end
      w_prod = w_ai * w_yi;
      if (int'(r_cnt) == int'(r_k))
         w_term = '0;
      else
         w_term = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
      w_acc_nx  = $signed(r_acc) + w_term;
      w_acc_abs = w_acc_nx[ACC_W-1] ? -w_acc_nx : w_acc_nx;
   end

   // r_acc holds the dividend during DIVIDE; quotient bits shift in at the bottom.
   always_comb begin
      w_rem_sh = {r_rem, r_acc[ACC_W-1]};
      w_ge     = (w_rem_sh >= {2'b00, r_div});
      w_diff   = w_rem_sh[WIDTH:0] - {1'b0, r_div};
      w_q_nx   = {r_acc[ACC_W-2:0], w_ge};
      w_q_lo   = r_neg ? -w_q_nx[WIDTH-1:0] : w_q_nx[WIDTH-1:0];
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_coef    <= '0;
         r_asg     <= '0;
         r_k       <= '0;
         r_div     <= '0;
         r_sgn     <= 1'b0;
         r_neg     <= 1'b0;
         r_acc     <= '0;
         r_rem     <= '0;
         out_ready <= 1'b1;
         out_valid <= 1'b0;
         out_bias  <= '0;
         out_variable_to_be_unchanged_sign <= 1'b0;
         out_active <= 1'b0;
`ifdef REDUCE_CLAUSE_SATURATE_EN
         out_overflow <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  out_ready <= 1'b0;
                  r_coef    <= in_coefficients[NUM_VARS*WIDTH-1:0];
                  r_asg     <= in_current_assignment;
                  r_k       <= in_variable_to_be_unchanged_index;
                  r_div     <= w_ak_mag;
                  r_sgn     <= ~w_ak[WIDTH-1];
                  r_acc     <= {{(ACC_W-WIDTH){w_an[WIDTH-1]}}, w_an};
                  r_cnt     <= '0;
                  r_state   <= (w_ak == '0) ? S_SKIP : S_ACCUM;
               end
            end
            S_SKIP: begin
               out_valid  <= 1'b1;
               out_bias   <= '0;
               out_active <= 1'b0;
               out_variable_to_be_unchanged_sign <= 1'b0;
`ifdef REDUCE_CLAUSE_SATURATE_EN
               out_overflow <= 1'b0;
`endif
               r_state <= S_DONE;
            end
            S_ACCUM: begin
               if (r_cnt == CNT_W'(NUM_VARS-1)) begin
                  r_acc   <= w_acc_abs;
                  r_neg   <= w_acc_nx[ACC_W-1];
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_DIVIDE;
               end else begin
                  r_acc <= w_acc_nx;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DIVIDE: begin
               r_acc <= w_q_nx;
               r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH:0];
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(ACC_W-1)) begin
                  out_valid  <= 1'b1;
                  out_active <= 1'b1;
                  out_variable_to_be_unchanged_sign <= r_sgn;
                  r_state    <= S_DONE;
`ifdef REDUCE_CLAUSE_SATURATE_EN
                  if (!r_neg && |w_q_nx[ACC_W-1:WIDTH-1]) begin
                     out_bias     <= {1'b0, {(WIDTH-1){1'b1}}};
                     out_overflow <= 1'b1;
                  end else if (r_neg && (|w_q_nx[ACC_W-1:WIDTH] ||
                               (w_q_nx[WIDTH-1] && |w_q_nx[WIDTH-2:0]))) begin
                     out_bias     <= {1'b1, {(WIDTH-1){1'b0}}};
                     out_overflow <= 1'b1;
                  end else begin
                     out_bias     <= w_q_lo;
                     out_overflow <= 1'b0;
                  end
`else
                  out_bias <= w_q_lo;
`endif
               end
            end
            S_DONE: begin
               if (in_ack) begin
                  out_valid <= 1'b0;
                  out_ready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reduce_clause_seq.sv
// Random and directed bench for reduce_clause_seq against an arithmetic model.
// Checks latency, handshake, backpressure, reset abort and wrap/clamp of the bias.
module tb_reduce_clause_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [23:0] coef;
   logic [15:0] asg;
   logic [1:0]  k;
   logic        out_valid;
   logic        ack;
   logic [7:0]  bias;
   logic        sgn;
   logic        act;
`ifdef REDUCE_CLAUSE_SATURATE_EN
   logic        ovf;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   reduce_clause_seq #(
      .NUM_VARS(2), .WIDTH(8), .INDEX_WIDTH(2)
   ) dut (
      .in_clk(clk),
      .in_reset(rst),
      .in_valid(in_valid),
      .out_ready(out_ready),
      .in_coefficients(coef),
      .in_current_assignment(asg),
      .in_variable_to_be_unchanged_index(k),
      .out_valid(out_valid),
      .in_ack(ack),
      .out_bias(bias),
      .out_variable_to_be_unchanged_sign(sgn),
      .out_active(act)
`ifdef REDUCE_CLAUSE_SATURATE_EN
      ,
      .out_overflow(ovf)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Reference: y_k kept, others substituted, divide by |a_k| toward zero.
   task automatic model(input int a0, a1, a2, y0, y1, kk,
                        output int e_act, e_sgn, e_bias, e_ovf);
      int ak, acc, q, mag;
      e_act = 0; e_sgn = 0; e_bias = 0; e_ovf = 0;
      ak = (kk == 0) ? a0 : (kk == 1) ? a1 : 0;
      if (ak != 0) begin
         acc = a2;
         if (kk != 0) acc += a0 * y0;
         if (kk != 1) acc += a1 * y1;
         mag = (ak < 0) ? -ak : ak;
         q = acc / mag;
         e_act = 1;
         e_sgn = (ak > 0) ? 1 : 0;
`ifdef REDUCE_CLAUSE_SATURATE_EN
         if (q > 127) begin
            e_bias = 127; e_ovf = 1;
         end else if (q < -128) begin
            e_bias = -128; e_ovf = 1;
         end else begin
            e_bias = q;
         end
`else
         e_bias = ((q % 256) + 256) % 256;
         if (e_bias > 127) e_bias -= 256;
`endif
      end
   endtask

   task automatic accept(input int a0, a1, a2, y0, y1, kk);
      int w;
      w = 0;
      while (!out_ready && w < 60) begin
         @(posedge clk); #1; w++;
      end
      chk("ready_before_req", int'(out_ready), 1);
      @(negedge clk);
      coef = {8'(a2), 8'(a1), 8'(a0)};
      asg  = {8'(y1), 8'(y0)};
      k    = 2'(kk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      coef = 24'($urandom);
      asg  = 16'($urandom);
      k    = 2'($urandom);
   endtask

   task automatic req(input int a0, a1, a2, y0, y1, kk, input int hold);
      int lat, e_act, e_sgn, e_bias, e_ovf;
      logic [7:0] b0;
      model(a0, a1, a2, y0, y1, kk, e_act, e_sgn, e_bias, e_ovf);
      accept(a0, a1, a2, y0, y1, kk);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, e_act ? 20 : 1);
      chk("valid", int'(out_valid), 1);
      chk("active", int'(act), e_act);
      chk("sign", int'(sgn), e_sgn);
      chk("bias", int'($signed(bias)), e_bias);
`ifdef REDUCE_CLAUSE_SATURATE_EN
      chk("overflow", int'(ovf), e_ovf);
`endif
      b0 = bias;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b1;
         coef = 24'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_ready", int'(out_ready), 0);
         chk("hold_bias", int'(bias), int'(b0));
      end
      @(negedge clk);
      in_valid = 1'b0;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      chk("ack_ready", int'(out_ready), 1);
      chk("ack_valid", int'(out_valid), 0);
   endtask

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   initial begin
      int a0, a1, a2, y0, y1, kk;
      rst = 1'b1; in_valid = 1'b0; ack = 1'b0;
      coef = '0; asg = '0; k = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", int'(out_ready), 1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_bias", int'(bias), 0);
      chk("rst_sign", int'(sgn), 0);
      chk("rst_active", int'(act), 0);
      rst = 1'b0;

      req(3, 2, 5, 4, 7, 0, 0);
      req(-4, 3, -2, 9, -5, 0, 0);
      req(5, 0, 1, 1, 1, 1, 0);
      req(5, 0, 1, 1, 1, 2, 0);
      req(3, 2, 5, 4, 7, 0, 5);
      req(1, 127, 127, 0, 127, 0, 0);
      req(-128, -128, -128, -128, -128, 1, 1);
      req(-128, -128, 127, 127, -128, 0, 0);
      req(7, 1, 0, 5, 9, 3, 2);

      // Abort mid-DIVIDE: nothing may come out afterwards.
      accept(3, 2, 5, 4, 7, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", int'(out_ready), 1);
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_bias", int'(bias), 0);
      chk("abort_active", int'(act), 0);
      chk("abort_sign", int'(sgn), 0);
      repeat (25) @(posedge clk);
      #1;
      chk("abort_no_output", int'(out_valid), 0);
      req(-4, 3, -2, 9, -5, 0, 1);

      for (int n = 0; n < 40; n++) begin
         a0 = rnd8(); a1 = rnd8(); a2 = rnd8();
         y0 = rnd8(); y1 = rnd8();
         kk = int'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            if (kk == 0) a0 = 0;
            else a1 = 0;
         end
         req(a0, a1, a2, y0, y1, kk, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
